// File: rtl/alu_issue_ctrl.sv
// Issue/writeback sequencer for the 8-bit ALU datapath: IDLE -> READ -> EXEC -> WB.
// Optional performance counters are enabled with the ALU_PERF_CNT_EN macro.
module alu_issue_ctrl #(
  parameter int reg_width  = 8,
  parameter int op_width   = 4,
  parameter int addr_width = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [op_width-1:0]   cmd_op,
  input  logic [addr_width-1:0] cmd_rd,
  input  logic [addr_width-1:0] cmd_rs,
  output logic [addr_width-1:0] rf_ra_addr,
  output logic [addr_width-1:0] rf_rb_addr,
  input  logic [reg_width-1:0]  rf_ra_data,
  input  logic [reg_width-1:0]  rf_rb_data,
  output logic [reg_width-1:0]  alu_ra,
  output logic [reg_width-1:0]  alu_rb,
  output logic [op_width-1:0]   alu_op,
  input  logic [reg_width-1:0]  alu_res,
  input  logic [reg_width-1:0]  alu_car,
  input  logic                  alu_zero,
  input  logic                  alu_branch,
  output logic                  rf_we,
  output logic [addr_width-1:0] rf_waddr,
  output logic [reg_width-1:0]  rf_wdata,
  output logic [reg_width-1:0]  car_q,
  output logic                  zero_q,
  output logic                  br_taken,
  output logic                  done,
  output logic                  err
`ifdef ALU_PERF_CNT_EN
  ,
  output logic [15:0]           perf_instr,
  output logic [15:0]           perf_ovf
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [op_width-1:0]   op_q;
  logic [addr_width-1:0] rd_q;
  logic                  cmd_ready_q;
  logic [addr_width-1:0] ra_addr_q, rb_addr_q;
  logic [reg_width-1:0]  opa_q, opb_q;
  logic [op_width-1:0]   alu_op_q;
  logic                  rf_we_q;
  logic [addr_width-1:0] rf_waddr_q;
  logic [reg_width-1:0]  rf_wdata_q;
  logic [reg_width-1:0]  car_reg_q;
  logic                  zero_reg_q;
  logic                  br_taken_q, done_q, err_q;

  function automatic logic op_writes_rf(input logic [op_width-1:0] op);
    case (32'(op))
      32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd8, 32'd9, 32'd10: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic op_updates_car(input logic [op_width-1:0] op);
    case (32'(op))
      32'd4, 32'd5, 32'd8, 32'd9, 32'd10: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic op_is_beq(input logic [op_width-1:0] op);
    return 32'(op) == 32'd7;
  endfunction

  function automatic logic op_is_illegal(input logic [op_width-1:0] op);
    return 32'(op) >= 32'd11;
  endfunction

  // Next-state sequencing; busy states ignore cmd_valid.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          state_d = S_READ;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, latched command, operands, flags and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_q        <= {op_width{1'b0}};
      rd_q        <= {addr_width{1'b0}};
      cmd_ready_q <= 1'b1;
      ra_addr_q   <= {addr_width{1'b0}};
      rb_addr_q   <= {addr_width{1'b0}};
      opa_q       <= {reg_width{1'b0}};
      opb_q       <= {reg_width{1'b0}};
      alu_op_q    <= {op_width{1'b0}};
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= {addr_width{1'b0}};
      rf_wdata_q  <= {reg_width{1'b0}};
      car_reg_q   <= {reg_width{1'b0}};
      zero_reg_q  <= 1'b0;
      br_taken_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      rf_we_q    <= 1'b0;
      br_taken_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q        <= cmd_op;
            rd_q        <= cmd_rd;
            ra_addr_q   <= cmd_rd;
            rb_addr_q   <= cmd_rs;
            alu_op_q    <= cmd_op;
            cmd_ready_q <= 1'b0;
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        S_READ: begin
          opa_q <= rf_ra_data;
          opb_q <= rf_rb_data;
        end
        // ALU outputs are sampled here so the WB-cycle outputs and flags line up with done.
        S_EXEC: begin
          done_q     <= 1'b1;
          rf_waddr_q <= rd_q;
          rf_wdata_q <= alu_res;
          if (op_writes_rf(op_q)) begin
            rf_we_q    <= 1'b1;
            zero_reg_q <= alu_zero;
          end
          if (op_updates_car(op_q)) begin
            car_reg_q <= alu_car;
          end
          if (op_is_beq(op_q)) begin
            br_taken_q <= alu_branch;
          end
          if (op_is_illegal(op_q)) begin
            err_q <= 1'b1;
          end
        end
        S_WB: begin
          cmd_ready_q <= 1'b1;
          alu_op_q    <= {op_width{1'b0}};
        end
        default: begin
          cmd_ready_q <= 1'b1;
          alu_op_q    <= {op_width{1'b0}};
        end
      endcase
    end
  end

`ifdef ALU_PERF_CNT_EN
  logic [15:0] perf_instr_q, perf_ovf_q;

  // Saturating retire and ADD/SUB overflow counters, updated alongside done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_instr_q <= 16'h0000;
      perf_ovf_q   <= 16'h0000;
    end else begin
      if (state_q == S_EXEC) begin
        if (perf_instr_q != 16'hFFFF) begin
          perf_instr_q <= perf_instr_q + 16'h0001;
        end
        if ((32'(op_q) == 32'd4 || 32'(op_q) == 32'd5) &&
            (alu_car != {reg_width{1'b0}}) && (perf_ovf_q != 16'hFFFF)) begin
          perf_ovf_q <= perf_ovf_q + 16'h0001;
        end
      end
    end
  end

  assign perf_instr = perf_instr_q;
  assign perf_ovf   = perf_ovf_q;
`endif

  assign cmd_ready  = cmd_ready_q;
  assign rf_ra_addr = ra_addr_q;
  assign rf_rb_addr = rb_addr_q;
  assign alu_ra     = opa_q;
  assign alu_rb     = opb_q;
  assign alu_op     = alu_op_q;
  assign rf_we      = rf_we_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_wdata   = rf_wdata_q;
  assign car_q      = car_reg_q;
  assign zero_q     = zero_reg_q;
  assign br_taken   = br_taken_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: register file and ALU environment,
// transaction-level reference model, directed test-plan items and random traffic.
module tb_alu_issue_ctrl;
  logic       clk, rst_n, cmd_valid, cmd_ready;
  logic [3:0] cmd_op, alu_op;
  logic [2:0] cmd_rd, cmd_rs, rf_ra_addr, rf_rb_addr, rf_waddr;
  logic [7:0] rf_ra_data, rf_rb_data, alu_ra, alu_rb, alu_res, alu_car, rf_wdata, car_q;
  logic       alu_zero, alu_branch, rf_we, zero_q, br_taken, done, err;
`ifdef ALU_PERF_CNT_EN
  logic [15:0] perf_instr, perf_ovf;
`endif

  logic [7:0]  rf  [8];
  logic [7:0]  mrf [8];
  logic [17:0] alu_o;
  int checks = 0;
  int failures = 0;

  // Reference model: phase counter since acceptance plus expected results.
  int         m_ph;
  logic [3:0] m_op;
  logic [2:0] m_rd, m_rs;
  logic [7:0] m_a, m_b, m_res, m_car;
  logic       m_zero, m_wb, m_br, m_err;
  int         m_pi, m_po;

  alu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rs(cmd_rs),
    .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
    .rf_ra_data(rf_ra_data), .rf_rb_data(rf_rb_data),
    .alu_ra(alu_ra), .alu_rb(alu_rb), .alu_op(alu_op),
    .alu_res(alu_res), .alu_car(alu_car), .alu_zero(alu_zero), .alu_branch(alu_branch),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .car_q(car_q), .zero_q(zero_q), .br_taken(br_taken), .done(done), .err(err)
`ifdef ALU_PERF_CNT_EN
    , .perf_instr(perf_instr), .perf_ovf(perf_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU: {branch, zero, carry[7:0], result[7:0]}
  function automatic logic [17:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [8:0]  s;
    logic [15:0] w;
    logic [7:0]  r, c;
    s = 9'd0; w = 16'd0; r = a; c = 8'h00;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: r = a ^ b;
      4'd3: r = ~a;
      4'd4: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = {7'd0, s[8]}; end
      4'd5: begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; c = {7'd0, s[8]}; end
      4'd6: r = a + b;
      4'd8: begin w = {8'h00, a} << b[2:0]; r = w[7:0]; c = w[15:8]; end
      4'd9: begin w = {a, 8'h00} >> b[2:0]; r = w[15:8]; c = w[7:0]; end
      4'd10: begin w = $signed({a, 8'h00}) >>> b[2:0]; r = w[15:8]; c = w[7:0]; end
      default: r = a;
    endcase
    return {(a == b), (r == 8'h00), c, r};
  endfunction

  assign rf_ra_data = rf[rf_ra_addr];
  assign rf_rb_data = rf[rf_rb_addr];
  assign alu_o      = alu_f(alu_op, alu_ra, alu_rb);
  assign alu_res    = alu_o[7:0];
  assign alu_car    = alu_o[15:8];
  assign alu_zero   = alu_o[16];
  assign alu_branch = alu_o[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_car = 8'h00; m_zero = 1'b0; m_pi = 0; m_po = 0;
    m_wb = 1'b0; m_br = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_edge();
    logic [17:0] o;
    case (m_ph)
      0: if (cmd_valid) begin
        m_op = cmd_op; m_rd = cmd_rd; m_rs = cmd_rs;
        m_a = mrf[cmd_rd]; m_b = mrf[cmd_rs];
        m_ph = 1;
      end
      1: m_ph = 2;
      2: begin
        o     = alu_f(m_op, m_a, m_b);
        m_res = o[7:0];
        m_wb  = (m_op <= 4'd5) || (m_op >= 4'd8 && m_op <= 4'd10);
        m_br  = (m_op == 4'd7) && o[17];
        m_err = (m_op >= 4'd11);
        if (m_wb) begin
          mrf[m_rd] = m_res;
          m_zero    = o[16];
        end
        if (m_op == 4'd4 || m_op == 4'd5 || (m_op >= 4'd8 && m_op <= 4'd10)) m_car = o[15:8];
        if (m_pi < 65535) m_pi++;
        if ((m_op == 4'd4 || m_op == 4'd5) && o[15:8] != 8'h00 && m_po < 65535) m_po++;
        m_ph = 3;
      end
      default: m_ph = 0;
    endcase
  endtask

  task automatic compare();
    chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, m_ph == 0});
    chk("done", {31'd0, done}, {31'd0, m_ph == 3});
    chk("rf_we", {31'd0, rf_we}, {31'd0, m_ph == 3 && m_wb});
    chk("err", {31'd0, err}, {31'd0, m_ph == 3 && m_err});
    chk("br_taken", {31'd0, br_taken}, {31'd0, m_ph == 3 && m_br});
    chk("car_q", {24'd0, car_q}, {24'd0, m_car});
    chk("zero_q", {31'd0, zero_q}, {31'd0, m_zero});
    chk("alu_op", {28'd0, alu_op}, (m_ph == 0) ? 32'd0 : {28'd0, m_op});
    if (m_ph == 1) begin
      chk("rf_ra_addr", {29'd0, rf_ra_addr}, {29'd0, m_rd});
      chk("rf_rb_addr", {29'd0, rf_rb_addr}, {29'd0, m_rs});
    end
    if (m_ph == 2) begin
      chk("alu_ra", {24'd0, alu_ra}, {24'd0, m_a});
      chk("alu_rb", {24'd0, alu_rb}, {24'd0, m_b});
    end
    if (m_ph == 3 && m_wb) begin
      chk("rf_waddr", {29'd0, rf_waddr}, {29'd0, m_rd});
      chk("rf_wdata", {24'd0, rf_wdata}, {24'd0, m_res});
    end
`ifdef ALU_PERF_CNT_EN
    chk("perf_instr", {16'd0, perf_instr}, m_pi);
    chk("perf_ovf", {16'd0, perf_ovf}, m_po);
`endif
  endtask

  // One clock: drive inputs, let the edge happen, then check at the falling edge.
  task automatic step(input logic v, input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs);
    cmd_valid = v; cmd_op = op; cmd_rd = rd; cmd_rs = rs;
    @(posedge clk);
    if (rf_we) rf[rf_waddr] = rf_wdata;
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic run_cmd(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs);
    step(1'b1, op, rd, rs);
    step(1'b0, 4'd0, 3'd0, 3'd0);
    step(1'b0, 4'd0, 3'd0, 3'd0);
  endtask

  task automatic poke(input logic [2:0] a, input logic [7:0] v);
    rf[a] = v; mrf[a] = v;
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_br", {31'd0, br_taken}, 32'd0);
    chk("rst_car", {24'd0, car_q}, 32'd0);
    chk("rst_zero", {31'd0, zero_q}, 32'd0);
    chk("rst_alu_op", {28'd0, alu_op}, 32'd0);
    chk("rst_alu_ra", {24'd0, alu_ra}, 32'd0);
    chk("rst_alu_rb", {24'd0, alu_rb}, 32'd0);
    chk("rst_wdata", {24'd0, rf_wdata}, 32'd0);
    chk("rst_waddr", {29'd0, rf_waddr}, 32'd0);
    chk("rst_ra_addr", {29'd0, rf_ra_addr}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int dcnt, rcnt;
    rst_n = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_rd = 3'd0; cmd_rs = 3'd0;
    for (int i = 0; i < 8; i++) poke(3'(i), 8'($urandom_range(0, 255)));
    model_reset();
    do_reset();
    step(1'b0, 4'd0, 3'd0, 3'd0);

    // ADD 0xF0 + 0x20
    poke(3'd1, 8'hF0); poke(3'd2, 8'h20);
    run_cmd(4'd4, 3'd1, 3'd2);
    chk("add_we", {31'd0, rf_we}, 32'd1);
    chk("add_waddr", {29'd0, rf_waddr}, 32'd1);
    chk("add_wdata", {24'd0, rf_wdata}, 32'h10);
    chk("add_car", {24'd0, car_q}, 32'h01);
    chk("add_zero", {31'd0, zero_q}, 32'd0);
    step(1'b0, 4'd0, 3'd0, 3'd0);

    // SLL 0xB4 << 2, then AND 0x0F & 0xF0
    poke(3'd3, 8'hB4); poke(3'd4, 8'h02);
    run_cmd(4'd8, 3'd3, 3'd4);
    chk("sll_wdata", {24'd0, rf_wdata}, 32'hD0);
    chk("sll_car", {24'd0, car_q}, 32'h02);
    step(1'b0, 4'd0, 3'd0, 3'd0);
    poke(3'd7, 8'h0F); poke(3'd0, 8'hF0);
    run_cmd(4'd0, 3'd7, 3'd0);
    chk("and_wdata", {24'd0, rf_wdata}, 32'h00);
    chk("and_zero", {31'd0, zero_q}, 32'd1);
    chk("and_car", {24'd0, car_q}, 32'h02);
    step(1'b0, 4'd0, 3'd0, 3'd0);

    // BEQ taken, then not taken
    poke(3'd5, 8'h55); poke(3'd6, 8'h55);
    run_cmd(4'd7, 3'd5, 3'd6);
    chk("beq_taken", {31'd0, br_taken}, 32'd1);
    chk("beq_we", {31'd0, rf_we}, 32'd0);
    chk("beq_car", {24'd0, car_q}, 32'h02);
    step(1'b0, 4'd0, 3'd0, 3'd0);
    chk("beq_pulse", {31'd0, br_taken}, 32'd0);
    poke(3'd6, 8'h54);
    run_cmd(4'd7, 3'd5, 3'd6);
    chk("beq_not_taken", {31'd0, br_taken}, 32'd0);
    step(1'b0, 4'd0, 3'd0, 3'd0);

    // Illegal opcode, then a normal ADD (rf[1]=0x10 from the first ADD)
    run_cmd(4'd12, 3'd1, 3'd2);
    chk("ill_done", {31'd0, done}, 32'd1);
    chk("ill_err", {31'd0, err}, 32'd1);
    chk("ill_we", {31'd0, rf_we}, 32'd0);
    step(1'b0, 4'd0, 3'd0, 3'd0);
    run_cmd(4'd4, 3'd1, 3'd2);
    chk("add2_wdata", {24'd0, rf_wdata}, 32'h30);
    chk("add2_car", {24'd0, car_q}, 32'h00);
    step(1'b0, 4'd0, 3'd0, 3'd0);

    // cmd_valid held for 8 cycles: two commands, 4 cycles apart
    dcnt = 0; rcnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (k < 4) step(1'b1, 4'd5, 3'd2, 3'd1);
      else       step(1'b1, 4'd9, 3'd3, 3'd4);
      if (done) dcnt++;
      if (cmd_ready) rcnt++;
    end
    chk("b2b_done_cnt", dcnt, 32'd2);
    chk("b2b_ready_cnt", rcnt, 32'd2);
    step(1'b0, 4'd0, 3'd0, 3'd0);

    // Reset during EXEC of an ADD aborts it
    step(1'b1, 4'd4, 3'd1, 3'd2);
    step(1'b0, 4'd0, 3'd0, 3'd0);
    do_reset();
    step(1'b0, 4'd0, 3'd0, 3'd0);
    run_cmd(4'd4, 3'd2, 3'd2);
    step(1'b0, 4'd0, 3'd0, 3'd0);

    // Random traffic, including ignored valids while busy and rare resets
    for (int n = 0; n < 800; n++) begin
      step(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Multi-cycle issue/writeback sequencer for the 8-bit datapath; it is the initiator side of the ALU interface.
- Accepts one decoded command per handshake and reads both operands from the register file.
- Drives alu op/operands, samples result, carry, zero and branch, and writes the result back.
- Sits between decode and the ALU/register file; owns the architectural carry register and the branch-taken flag.

Parameters:
reg_width, 8, datapath and register width
op_width, 4, ALU opcode width
addr_width, 3, register-file address width (8 registers)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready
cmd_op  in  op_width  ALU opcode
cmd_rd  in  addr_width  destination / operand A register
cmd_rs  in  addr_width  operand B register
rf_ra_addr  out  addr_width  register-file read port A address
rf_rb_addr  out  addr_width  register-file read port B address
rf_ra_data  in  reg_width  read data A (combinational read)
rf_rb_data  in  reg_width  read data B (combinational read)
alu_ra  out  reg_width  ALU operand A
alu_rb  out  reg_width  ALU operand B
alu_op  out  op_width  ALU opcode
alu_res  in  reg_width  ALU result
alu_car  in  reg_width  ALU carry/overflow/shift-out
alu_zero  in  1  ALU zero flag
alu_branch  in  1  ALU branch compare
rf_we  out  1  writeback enable, one-cycle pulse
rf_waddr  out  addr_width  writeback address
rf_wdata  out  reg_width  writeback data
car_q  out  reg_width  architectural carry register
zero_q  out  1  zero flag of last completed writeback op
br_taken  out  1  one-cycle pulse, BEQ taken
done  out  1  one-cycle pulse, command retired
err  out  1  one-cycle pulse coincident with done, illegal opcode

Behaviour:
- Reset (async, rst_n=0): state IDLE. cmd_ready=1 after release. rf_we, br_taken, done, err=0. car_q=0, zero_q=0. All address/data/alu outputs=0.
- Reset mid-operation aborts immediately. No rf_we pulse is ever issued for the aborted command.
- FSM is IDLE -> READ -> EXEC -> WB -> IDLE, one cycle per state.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch op/rd/rs and go to READ.
  - cmd_ready=0 in every other state; cmd_valid held while busy is ignored.
- READ:
  - rf_ra_addr=rd, rf_rb_addr=rs.
  - Register rf_ra_data/rf_rb_data into operand regs at the clock edge.
  - rd==rs is legal (both operands equal).
- EXEC:
  - alu_ra/alu_rb come from the operand regs; alu_op = latched op.
  - Sample alu_res, alu_car, alu_zero, alu_branch into internal regs at the edge.
  - alu_op is held at the latched op in all non-IDLE states and is 0 in IDLE.
- WB (single cycle):
  - done=1.
  - Ops 0,1,2,3,4,5,8,9,10: rf_we=1, rf_waddr=rd, rf_wdata=sampled result, zero_q<=sampled zero.
  - Ops 4,5,8,9,10 additionally: car_q<=sampled alu_car. All other ops leave car_q unchanged.
  - Op 6 (LW/SW pass-through): rf_we=0; result is not written back (memory path consumes alu_res externally).
  - Op 7 (BEQ): rf_we=0, br_taken=sampled alu_branch; car_q and zero_q are unchanged.
  - Ops 11-15: err=1, rf_we=0, no flag updates.
- Latency: accept edge to done = 3 cycles. Throughput is 1 command per 4 cycles.
- Flag widths: car_q holds the full reg_width alu_car (bit 0 only for ADD/SUB; full width for shifts). Operand 3 (NOT) still reads rs; its value is ignored by the ALU.
- Simultaneous events: done/err/br_taken pulses and cmd_ready=1 never overlap. The next command can be accepted the cycle after WB.

Optional Feature:
- Macro: ALU_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_instr[15:0] and perf_ovf[15:0], both reset to 0.
  - perf_instr increments on every done.
  - perf_ovf increments on done when op is 4 or 5 and the sampled alu_car is nonzero.
  - Both counters saturate at 16'hFFFF.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- ADD rd=1 (0xF0), rs=2 (0x20) -> done 3 cycles after accept; rf_we=1, waddr=1, wdata=0x10; car_q=0x01; zero_q=0.
- SLL rd=3 (0xB4), rs=4 (0x02) -> wdata=0xD0, car_q=0x02. Follow with AND 0x0F&0xF0 -> wdata=0x00, zero_q=1, car_q still 0x02.
- BEQ rd=5, rs=6, both 0x55 -> br_taken=1 for one cycle, rf_we=0, car_q/zero_q unchanged. Repeat with 0x55 vs 0x54 -> br_taken=0.
- Opcode 12 -> done=1 and err=1 in the same cycle, rf_we=0, flags unchanged. A subsequent legal ADD completes normally.
- cmd_valid held high for 8 cycles with two back-to-back commands -> cmd_ready high only in IDLE; commands retire 4 cycles apart, in order.
- rst_n pulsed low during EXEC of ADD -> all outputs return to reset values asynchronously; no rf_we; car_q=0. Next command behaves normally.
